ofmap_writer: RTL and testbench

OFMAP_WRITER -- requirements
Module: ofmap_writer

---
 rtl/ofmap_writer.sv | 88 ++++++++
 tb/tb_ofmap_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writer.sv
// Assembles an OHxOW output feature map from half-row beats; each accepted beat is visible in fmap next cycle.
// in_ready is high only while filling; the full map is held (and input refused) until fmap_ack or start.
module ofmap_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [0:((W-F+1)/2)*DATA_WIDTH-1]                     in_data,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  output logic [5:0]                                            row_number,
  output logic [5:0]                                            column,
  output logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]                 fmap,
  output logic                                                  fmap_valid,
  input  logic                                                  fmap_ack
);
  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int HALF = OW / 2;
  localparam int NPIX = OH * OW;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                  r_state;
  logic [5:0]              r_row;
  logic [5:0]              r_col;
  logic                    r_fmap_valid;
  logic [DATA_WIDTH-1:0]   r_pix [NPIX];
  logic [AW-1:0]           w_base;

  assign w_base     = AW'(r_row * OW + r_col * HALF);
  assign in_ready   = (r_state == FILL);
  assign row_number = r_row;
  assign column     = r_col;
  assign fmap_valid = r_fmap_valid;

  for (genvar k = 0; k < NPIX; k++) begin : g_fmap
    assign fmap[k*DATA_WIDTH +: DATA_WIDTH] = r_pix[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_fmap_valid <= 1'b0;
      for (int k = 0; k < NPIX; k++) r_pix[k] <= '0;
    end else if (start) begin
      // Restart wins over any coincident beat or ack; old pixels stay until overwritten.
      r_state      <= FILL;
      r_row        <= '0;
      r_col        <= '0;
      r_fmap_valid <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            for (int j = 0; j < HALF; j++)
              r_pix[w_base + AW'(j)] <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
            if (r_col == 6'd0) begin
              r_col <= 6'd1;
            end else if (r_row == 6'(OH - 1)) begin
              r_state      <= FULL;
              r_fmap_valid <= 1'b1;
            end else begin
              r_row <= r_row + 6'd1;
              r_col <= 6'd0;
            end
          end
        end
        FULL: begin
          if (fmap_ack) begin
            r_state      <= IDLE;
            r_fmap_valid <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer with the default 32x32 image and 5x5 kernel (28x28 map, 14-pixel beats).
module tb_ofmap_writer;
  localparam int DW   = 16;
  localparam int OH   = 28;
  localparam int OW   = 28;
  localparam int HALF = 14;
  localparam int NPIX = OH * OW;
  localparam int NBEAT = OH * 2;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [0:HALF*DW-1]          in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [5:0]                  row_number;
  logic [5:0]                  column;
  logic [0:NPIX*DW-1]          fmap;
  logic                        fmap_valid;
  logic                        fmap_ack;

  logic [0:NPIX*DW-1]          exp_fmap;
  int n_cmp = 0;
  int n_err = 0;

  ofmap_writer #(.DATA_WIDTH(16), .H(32), .W(32), .F(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .row_number(row_number),
    .column(column), .fmap(fmap), .fmap_valid(fmap_valid), .fmap_ack(fmap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: all zero, 1: pixel(r,c)=r*28+c, 2: all 0xFFFF
  task automatic build_exp(input int mode);
    for (int p = 0; p < NPIX; p++)
      exp_fmap[p*DW +: DW] = (mode == 0) ? 16'h0 : (mode == 1) ? 16'(p) : 16'hFFFF;
  endtask

  task automatic chk_fmap(input string tag);
    int bad;
    bad = -1;
    for (int p = NPIX - 1; p >= 0; p--)
      if (fmap[p*DW +: DW] !== exp_fmap[p*DW +: DW]) bad = p;
    n_cmp++;
    assert (fmap === exp_fmap) else begin
      n_err++;
      $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, bad,
             fmap[bad*DW +: DW], exp_fmap[bad*DW +: DW]);
    end
  endtask

  task automatic chk_pix(input string tag, input int r, input int c, input logic [15:0] exp);
    chk(tag, 64'(fmap[(r*OW + c)*DW +: DW]), 64'(exp));
  endtask

  // Sends n beats (ffff: all 0xFFFF, else element j of beat b = b*14+j), optionally with an idle cycle before each.
  task automatic send_beats(input int n, input bit ffff, input bit bp);
    int pos;
    for (int b = 0; b < n; b++) begin
      if (bp) begin
        in_valid = 1'b0;
        for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = 16'h1234;
        step();
        chk("bp_hold_row", 64'(row_number), 64'(b / 2));
        chk("bp_hold_col", 64'(column), 64'(b % 2));
      end
      in_valid = 1'b1;
      for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = ffff ? 16'hFFFF : 16'(b * HALF + j);
      step();
      pos = b + 1;
      chk("beat_row", 64'(row_number), 64'((pos == NBEAT) ? OH - 1 : pos / 2));
      chk("beat_col", 64'(column), 64'((pos == NBEAT) ? 1 : pos % 2));
      chk("beat_fvalid", 64'(fmap_valid), 64'(pos == NBEAT));
      chk("beat_ready", 64'(in_ready), 64'(pos != NBEAT));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; fmap_ack = 1'b0; in_data = '0;
    #3;
    build_exp(0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_fvalid", 64'(fmap_valid), 64'd0);
    chk("rst_row", 64'(row_number), 64'd0);
    chk("rst_col", 64'(column), 64'd0);
    chk_fmap("rst_fmap");
    step(); step();
    rst_n = 1'b1;
    step();

    // Idle ignores beats and acks
    in_valid = 1'b1; fmap_ack = 1'b1;
    for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = 16'hBEEF;
    step();
    in_valid = 1'b0; fmap_ack = 1'b0;
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_col", 64'(column), 64'd0);
    chk_fmap("idle_fmap");

    // Full back-to-back fill
    start = 1'b1; step(); start = 1'b0;
    chk("start_ready", 64'(in_ready), 64'd1);
    chk("start_row", 64'(row_number), 64'd0);
    send_beats(NBEAT, 1'b0, 1'b0);
    build_exp(1);
    chk_fmap("fill_fmap");
    chk_pix("fill_px_0_27", 0, 27, 16'd27);
    chk_pix("fill_px_27_14", 27, 14, 16'd770);

    // Hold in FULL with beats offered
    in_valid = 1'b1;
    for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = 16'hAAAA;
    for (int i = 0; i < 10; i++) step();
    in_valid = 1'b0;
    chk_fmap("hold_fmap");
    chk("hold_row", 64'(row_number), 64'd27);
    chk("hold_col", 64'(column), 64'd1);
    chk("hold_fvalid", 64'(fmap_valid), 64'd1);
    chk("hold_ready", 64'(in_ready), 64'd0);
    fmap_ack = 1'b1; step(); fmap_ack = 1'b0;
    chk("ack_fvalid", 64'(fmap_valid), 64'd0);
    chk("ack_ready", 64'(in_ready), 64'd0);
    chk("ack_row", 64'(row_number), 64'd0);
    chk("ack_col", 64'(column), 64'd0);
    chk_fmap("ack_fmap_kept");

    // Restart after 20 beats of 0xFFFF; coincident beat must be dropped
    start = 1'b1; step(); start = 1'b0;
    send_beats(20, 1'b1, 1'b0);
    chk_pix("part_px_9_27", 9, 27, 16'hFFFF);
    chk_pix("part_px_10_0", 10, 0, 16'd280);
    start = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = 16'h7777;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("abort_row", 64'(row_number), 64'd0);
    chk("abort_col", 64'(column), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk_pix("abort_px_0_0", 0, 0, 16'hFFFF);
    chk_pix("abort_px_27_27", 27, 27, 16'd783);
    send_beats(NBEAT, 1'b1, 1'b0);
    build_exp(2);
    chk_fmap("restart_fmap");

    // Back-pressure fill over the all-ones map
    fmap_ack = 1'b1; step(); fmap_ack = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    send_beats(NBEAT, 1'b0, 1'b1);
    build_exp(1);
    chk_fmap("bp_fmap");

    // start with ack in FULL: start wins
    start = 1'b1; fmap_ack = 1'b1; step(); start = 1'b0; fmap_ack = 1'b0;
    chk("both_ready", 64'(in_ready), 64'd1);
    chk("both_fvalid", 64'(fmap_valid), 64'd0);
    chk("both_row", 64'(row_number), 64'd0);
    send_beats(5, 1'b1, 1'b0);

    // Async reset between edges mid-fill
    #3 rst_n = 1'b0;
    #1;
    build_exp(0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    chk("arst_row", 64'(row_number), 64'd0);
    chk("arst_col", 64'(column), 64'd0);
    chk("arst_fvalid", 64'(fmap_valid), 64'd0);
    chk_fmap("arst_fmap");
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = 16'h5A5A;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_ready", 64'(in_ready), 64'd0);
    chk("post_rst_col", 64'(column), 64'd0);
    chk_fmap("post_rst_fmap");
    start = 1'b1; in_valid = 1'b0; step(); start = 1'b0;
    chk("post_rst_start", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
